// File: rtl/llsc_mem_ctrl.sv
`timescale 1ns/1ps
// MEM-stage LL/SC controller: runs LW/SW/LL/SC over a single-outstanding bus
// handshake, decides SC success and drives the link-bit register write port.
module llsc_mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              op_valid,
  input  logic [1:0]        op_type,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              LLbit_i,
  input  logic              wb_LLbit_we,
  input  logic              wb_LLbit_value,
  input  logic              snoop_valid,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              stall_req,
  output logic              done,
  output logic [DATA_W-1:0] rdata_o,
  output logic              LLbit_we_o,
  output logic              LLbit_value_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;
  typedef enum logic [1:0] {OP_LW = 2'b00, OP_SW = 2'b01, OP_LL = 2'b10, OP_SC = 2'b11} op_t;

  state_t            state, next_state;
  op_t               op_q;
  logic              flush_q;
  logic [ADDR_W-1:0] link_addr;

  logic eff_ll, snoop_hit, snoop_hit_new, accept, sc_fail;
  logic commit, ll_commit, sc_commit;
  logic llbit_we_n, llbit_value_n;
  logic unused_bits;

  assign unused_bits = &snoop_addr[1:0];

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    next_state    = state;
    llbit_we_n    = 1'b0;
    llbit_value_n = 1'b0;

    eff_ll    = wb_LLbit_we ? wb_LLbit_value : LLbit_i;
    snoop_hit = snoop_valid && (snoop_addr[ADDR_W-1:2] == link_addr[ADDR_W-1:2]);
    accept    = (state == IDLE) && op_valid && !flush;
    sc_fail   = accept && (op_t'(op_type) == OP_SC) && (!eff_ll || snoop_hit);
    // A flush seen at any point of the bus phase suppresses the response.
    commit    = (state == BUS) && bus_ack && !flush_q && !flush;
    ll_commit = commit && (op_q == OP_LL);
    sc_commit = (commit && (op_q == OP_SC)) || sc_fail;
    // A store racing the LL ack to the address being linked also kills the link.
    snoop_hit_new = ll_commit && snoop_valid &&
                    (snoop_addr[ADDR_W-1:2] == bus_addr[ADDR_W-1:2]);

    case (state)
      IDLE:    if (accept) next_state = sc_fail ? RESP : BUS;
      BUS:     if (bus_ack) next_state = (flush_q || flush) ? IDLE : RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase

    if (snoop_hit || snoop_hit_new) begin
      llbit_we_n    = 1'b1;
      llbit_value_n = 1'b0;
    end else if (ll_commit) begin
      llbit_we_n    = 1'b1;
      llbit_value_n = 1'b1;
    end else if (sc_commit) begin
      llbit_we_n    = 1'b1;
      llbit_value_n = 1'b0;
    end

    bus_req   = (state == BUS);
    bus_we    = (state == BUS) && ((op_q == OP_SW) || (op_q == OP_SC));
    done      = (state == RESP) && !flush;
    stall_req = op_valid && (state != RESP) && !rst;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q          <= OP_LW;
      flush_q       <= 1'b0;
      bus_addr      <= '0;
      bus_wdata     <= '0;
      rdata_o       <= '0;
      link_addr     <= '0;
      LLbit_we_o    <= 1'b0;
      LLbit_value_o <= 1'b0;
    end else begin
      LLbit_we_o    <= llbit_we_n;
      LLbit_value_o <= llbit_value_n;

      if (accept) begin
        op_q      <= op_t'(op_type);
        bus_addr  <= addr;
        bus_wdata <= wdata;
        flush_q   <= 1'b0;
      end else if ((state == BUS) && flush) begin
        flush_q <= 1'b1;
      end

      if (sc_fail) begin
        rdata_o <= '0;
      end else if (commit) begin
        case (op_q)
          OP_LW, OP_LL: rdata_o <= bus_rdata;
          OP_SC:        rdata_o <= DATA_W'(1);
          default:      rdata_o <= '0;
        endcase
      end

      if (ll_commit) link_addr <= bus_addr;
    end
  end

endmodule

// File: tb/tb_llsc_mem_ctrl.sv
`timescale 1ns/1ps
// Bench for llsc_mem_ctrl: directed LL/SC scenarios plus randomized traffic,
// responses checked by a queue-based scoreboard against a link/memory model.
module tb_llsc_mem_ctrl;

  localparam logic [1:0] LW = 2'b00, SW = 2'b01, LL = 2'b10, SC = 2'b11;

  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, op_valid = 1'b0;
  logic [1:0]  op_type = 2'b00;
  logic [31:0] addr = '0, wdata = '0;
  logic        LLbit_i, wb_LLbit_we = 1'b0, wb_LLbit_value = 1'b0;
  logic        drv_snoop = 1'b0, rsp_snoop = 1'b0;
  logic [31:0] drv_snoop_addr = '0, rsp_snoop_addr = '0;
  logic        snoop_valid;
  logic [31:0] snoop_addr;
  logic        bus_req, bus_we, bus_ack = 1'b0;
  logic [31:0] bus_addr, bus_wdata, bus_rdata = '0;
  logic        stall_req, done, LLbit_we_o, LLbit_value_o;
  logic [31:0] rdata_o;
  logic        llbit_reg;

  assign snoop_valid = drv_snoop | rsp_snoop;
  assign snoop_addr  = rsp_snoop ? rsp_snoop_addr : drv_snoop_addr;
  assign LLbit_i     = llbit_reg;

  llsc_mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .op_valid(op_valid), .op_type(op_type),
    .addr(addr), .wdata(wdata), .LLbit_i(LLbit_i), .wb_LLbit_we(wb_LLbit_we),
    .wb_LLbit_value(wb_LLbit_value), .snoop_valid(snoop_valid), .snoop_addr(snoop_addr),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .stall_req(stall_req), .done(done),
    .rdata_o(rdata_o), .LLbit_we_o(LLbit_we_o), .LLbit_value_o(LLbit_value_o)
  );

  always #5 clk = ~clk;

  // The link-bit register this controller feeds; it self-clears on flush.
  always @(posedge clk or posedge rst) begin
    if (rst)             llbit_reg <= 1'b0;
    else if (flush)      llbit_reg <= 1'b0;
    else if (LLbit_we_o) llbit_reg <= LLbit_value_o;
  end

  int tests = 0, fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] def_word(input logic [31:0] a);
    return ({a[31:2], 2'b00} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // ---------------- bus model ----------------
  logic [31:0] bus_mem [logic [29:0]];
  int ack_delay = -1;
  bit snoop_on_ack = 1'b0;

  initial forever begin
    @(negedge clk);
    if (bus_req && !rst) begin
      int d;
      d = (ack_delay >= 0) ? ack_delay : int'($urandom_range(0, 3));
      repeat (d) @(negedge clk);
      if (bus_req && !rst) begin
        bus_ack   = 1'b1;
        bus_rdata = bus_mem.exists(bus_addr[31:2]) ? bus_mem[bus_addr[31:2]] : def_word(bus_addr);
        if (bus_we) bus_mem[bus_addr[31:2]] = bus_wdata;
        if (snoop_on_ack) begin
          rsp_snoop      = 1'b1;
          rsp_snoop_addr = bus_addr | 32'h2;
        end
        @(negedge clk);
        bus_ack   = 1'b0;
        rsp_snoop = 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] data;
    bit          chk;
    bit          bus;
    int          cnt;
  } exp_t;
  exp_t exp_q[$];
  int   bus_cnt = 0;

  initial begin
    exp_t e;
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_req && !prev) bus_cnt++;
      prev = bus_req;
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          if (e.chk) check("rdata", rdata_o, e.data);
          check("bus_used", 32'(bus_cnt != e.cnt), 32'(e.bus));
        end
      end
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [logic [29:0]];
  bit          ref_valid = 1'b0;
  logic [31:0] ref_link = '0;

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : def_word(a);
  endfunction

  int   last_lat;
  logic last_we, last_val, last_stall;

  // Called right after a falling edge; returns right after the done sample.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_data, input bit chk, input bit exp_bus);
    bit got;
    exp_q.push_back('{data: exp_data, chk: chk, bus: exp_bus, cnt: bus_cnt});
    op_valid = 1'b1; op_type = op; addr = a; wdata = d;
    got = 1'b0; last_lat = 0;
    while (!got && last_lat < 50) begin
      @(negedge clk);
      last_lat++;
      if (done) begin
        got = 1'b1;
        last_we = LLbit_we_o; last_val = LLbit_value_o; last_stall = stall_req;
      end
    end
    op_valid = 1'b0;
    if (!got) begin
      check("done_timeout", 32'd0, 32'd1);
      void'(exp_q.pop_back());
    end
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return 32'h100;
      1:       return 32'h104;
      2:       return 32'h108;
      default: return 32'h200;
    endcase
  endfunction

  task automatic rand_op();
    logic [31:0] a, d, sa;
    logic [1:0]  op;
    a  = pick_addr();
    d  = $urandom;
    op = 2'($urandom_range(0, 3));
    case (op)
      LW: issue(LW, a, d, ref_read(a), 1'b1, 1'b1);
      SW: begin ref_mem[a[31:2]] = d; issue(SW, a, d, '0, 1'b0, 1'b1); end
      LL: begin issue(LL, a, d, ref_read(a), 1'b1, 1'b1); ref_valid = 1'b1; ref_link = a; end
      default: begin
        if (ref_valid) begin
          ref_mem[a[31:2]] = d;
          issue(SC, a, d, 32'd1, 1'b1, 1'b1);
        end else begin
          issue(SC, a, d, 32'd0, 1'b1, 1'b0);
        end
        ref_valid = 1'b0;
      end
    endcase
    @(negedge clk);
    check("rand_llbit", 32'(llbit_reg), 32'(ref_valid));
    if ($urandom_range(0, 3) == 0) begin
      sa = pick_addr() | 32'($urandom_range(0, 3));
      drv_snoop = 1'b1; drv_snoop_addr = sa;
      @(negedge clk);
      drv_snoop = 1'b0;
      if (sa[31:2] == ref_link[31:2]) ref_valid = 1'b0;
      @(negedge clk);
      check("rand_llbit_snoop", 32'(llbit_reg), 32'(ref_valid));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  held;
    bit  seen_done;

    repeat (3) @(negedge clk);
    check("rst_bus_req", 32'(bus_req), 0);
    check("rst_done", 32'(done), 0);
    check("rst_stall", 32'(stall_req), 0);
    check("rst_llbit_we", 32'(LLbit_we_o), 0);
    check("rst_rdata", rdata_o, 0);
    check("rst_bus_addr", bus_addr, 0);
    rst = 1'b0;
    @(negedge clk);

    // LL then SC
    bus_mem[32'h100 >> 2] = 32'hDEAD_BEEF;
    ref_mem[32'h100 >> 2] = 32'hDEAD_BEEF;
    issue(LL, 32'h100, '0, 32'hDEAD_BEEF, 1'b1, 1'b1);
    check("ll_we", 32'(last_we), 1);
    check("ll_val", 32'(last_val), 1);
    check("ll_stall_at_done", 32'(last_stall), 0);
    ref_valid = 1'b1; ref_link = 32'h100;
    @(negedge clk);
    check("ll_reg", 32'(llbit_reg), 1);
    ref_mem[32'h100 >> 2] = 32'hCAFE_F00D;
    issue(SC, 32'h100, 32'hCAFE_F00D, 32'd1, 1'b1, 1'b1);
    check("sc_we", 32'(last_we), 1);
    check("sc_val", 32'(last_val), 0);
    check("sc_mem", bus_mem[32'h100 >> 2], 32'hCAFE_F00D);
    ref_valid = 1'b0;
    @(negedge clk);

    // SC fail: no bus, done on the next cycle
    issue(SC, 32'h100, 32'h1111_1111, 32'd0, 1'b1, 1'b0);
    check("scf_latency", last_lat, 1);
    check("scf_we", 32'(last_we), 1);
    check("scf_val", 32'(last_val), 0);
    @(negedge clk);

    // Forwarded link bit from WB wins over the register
    wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
    ref_mem[32'h104 >> 2] = 32'h2222_2222;
    issue(SC, 32'h104, 32'h2222_2222, 32'd1, 1'b1, 1'b1);
    wb_LLbit_we = 1'b0; wb_LLbit_value = 1'b0;
    @(negedge clk);
    issue(LL, 32'h108, '0, ref_read(32'h108), 1'b1, 1'b1);
    ref_link = 32'h108;
    @(negedge clk);
    check("fwd_reg_set", 32'(llbit_reg), 1);
    wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b0;
    issue(SC, 32'h108, 32'h3333_3333, 32'd0, 1'b1, 1'b0);
    check("fwd_fail_latency", last_lat, 1);
    wb_LLbit_we = 1'b0;
    ref_valid = 1'b0;
    @(negedge clk);

    // Snoop hit (low bits ignored), snoop miss, snoop on the LL ack edge
    issue(LL, 32'h100, '0, ref_read(32'h100), 1'b1, 1'b1);
    ref_link = 32'h100;
    @(negedge clk);
    drv_snoop = 1'b1; drv_snoop_addr = 32'h102;
    @(negedge clk);
    check("snoop_hit_we", 32'(LLbit_we_o), 1);
    check("snoop_hit_val", 32'(LLbit_value_o), 0);
    drv_snoop = 1'b0;
    @(negedge clk);
    check("snoop_hit_reg", 32'(llbit_reg), 0);
    issue(LL, 32'h100, '0, ref_read(32'h100), 1'b1, 1'b1);
    @(negedge clk);
    drv_snoop = 1'b1; drv_snoop_addr = 32'h104;
    @(negedge clk);
    check("snoop_miss_we", 32'(LLbit_we_o), 0);
    drv_snoop = 1'b0;
    @(negedge clk);
    check("snoop_miss_reg", 32'(llbit_reg), 1);
    snoop_on_ack = 1'b1; ack_delay = 2;
    issue(LL, 32'h100, '0, ref_read(32'h100), 1'b1, 1'b1);
    check("snoop_ack_we", 32'(last_we), 1);
    check("snoop_ack_val", 32'(last_val), 0);
    snoop_on_ack = 1'b0; ack_delay = -1;
    @(negedge clk);
    check("snoop_ack_reg", 32'(llbit_reg), 0);
    ref_valid = 1'b0;

    // Own SW to the linked word keeps the link
    issue(LL, 32'h108, '0, ref_read(32'h108), 1'b1, 1'b1);
    ref_link = 32'h108;
    ref_mem[32'h108 >> 2] = 32'h4444_4444;
    @(negedge clk);
    issue(SW, 32'h108, 32'h4444_4444, '0, 1'b0, 1'b1);
    check("own_sw_we", 32'(last_we), 0);
    @(negedge clk);
    check("own_sw_reg", 32'(llbit_reg), 1);
    ref_mem[32'h108 >> 2] = 32'h5555_5555;
    issue(SC, 32'h108, 32'h5555_5555, 32'd1, 1'b1, 1'b1);
    @(negedge clk);

    // Flush in BUS: bus held to the ack, no done afterwards
    ack_delay = 5;
    op_valid = 1'b1; op_type = LW; addr = 32'h104; wdata = '0;
    @(negedge clk);
    check("flush_bus_started", 32'(bus_req), 1);
    held = 1; seen_done = 1'b0;
    flush = 1'b1; op_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      flush = 1'b0;
      if (done) seen_done = 1'b1;
      if (bus_req) held++;
      else break;
    end
    check("flush_req_held", held, 6);
    repeat (3) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("flush_no_done", 32'(seen_done), 0);
    ack_delay = -1;
    ref_valid = 1'b0;
    issue(LW, 32'h104, '0, ref_read(32'h104), 1'b1, 1'b1);
    @(negedge clk);

    // Asynchronous reset mid-BUS
    ack_delay = 8;
    op_valid = 1'b1; op_type = SW; addr = 32'h300; wdata = 32'h6666_6666;
    @(negedge clk);
    check("arst_bus_started", 32'(bus_req), 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_bus_req", 32'(bus_req), 0);
    check("arst_stall", 32'(stall_req), 0);
    check("arst_done", 32'(done), 0);
    op_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    ack_delay = -1;
    ref_valid = 1'b0; ref_link = '0;
    issue(LW, 32'h300, '0, ref_read(32'h300), 1'b1, 1'b1);
    @(negedge clk);
    issue(SC, 32'h300, 32'h7777_7777, 32'd0, 1'b1, 1'b0);
    @(negedge clk);

    // Randomized traffic against the model
    for (int n = 0; n < 200; n++) rand_op();

    repeat (4) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
